// File: rtl/synth_spi_tx.sv
// SPI mode-0 initiator that sends one 16-bit {addr, data} configuration frame per request.
// Define SPI_TX_BURST_EN to chain queued frames without raising spi_nss between them.
module synth_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_addr,
    input  logic [11:0] req_data,
    output logic        busy,
    output logic        done,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_nss
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_SCK_HI = 3'd2;
    localparam logic [2:0] ST_SCK_LO = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

`ifdef SPI_TX_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic [2:0]  state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [3:0]  bit_reg, bit_next;
    logic [15:0] shift_reg, shift_next;
    logic        ready_reg, ready_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        sclk_reg, sclk_next;
    logic        mosi_reg, mosi_next;
    logic        nss_reg, nss_next;

    logic        div_last;
    logic        accept;

    assign div_last = (div_reg == DIV_MAX);
    assign accept   = req_valid && ready_reg;

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        sclk_next  = sclk_reg;
        mosi_next  = mosi_reg;
        nss_next   = nss_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SETUP;
                    div_next   = 8'd0;
                    bit_next   = 4'd0;
                    shift_next = {req_addr, req_data};
                    mosi_next  = req_addr[3];
                    nss_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    state_next = ST_SCK_HI;
                    div_next   = 8'd0;
                    sclk_next  = 1'b1;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_SCK_HI: begin
                if (div_last) begin
                    div_next  = 8'd0;
                    sclk_next = 1'b0;
                    // bit counter wraps to 0 after the 16th bit, ready for the next frame
                    bit_next  = bit_reg + 4'd1;
                    if (bit_reg == 4'd15) begin
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_SCK_LO;
                        // rotate keeps every bit of the register live; the frame is restored after 16 steps
                        shift_next = {shift_reg[14:0], shift_reg[15]};
                        mosi_next  = shift_reg[14];
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_SCK_LO: begin
                if (div_last) begin
                    state_next = ST_SCK_HI;
                    div_next   = 8'd0;
                    sclk_next  = 1'b1;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_HOLD: begin
                if (div_last) begin
                    div_next  = 8'd0;
                    done_next = 1'b1;
                    if (BURST && accept) begin
                        // chained frame: nss stays low, first half-period carries the new MSB
                        state_next = ST_SCK_LO;
                        bit_next   = 4'd0;
                        shift_next = {req_addr, req_data};
                        mosi_next  = req_addr[3];
                    end else begin
                        state_next = ST_GAP;
                        nss_next   = 1'b1;
                        mosi_next  = 1'b0;
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_GAP: begin
                if (div_last) begin
                    state_next = ST_IDLE;
                    div_next   = 8'd0;
                    busy_next  = 1'b0;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                div_next   = 8'd0;
                bit_next   = 4'd0;
                busy_next  = 1'b0;
                sclk_next  = 1'b0;
                mosi_next  = 1'b0;
                nss_next   = 1'b1;
            end
        endcase

        // ready is registered, so it is raised one cycle ahead of the cycle it qualifies
        ready_next = (state_next == ST_IDLE) ||
                     (BURST && (state_next == ST_HOLD) && (div_next == DIV_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            div_reg   <= 8'd0;
            bit_reg   <= 4'd0;
            shift_reg <= 16'd0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            nss_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            nss_reg   <= nss_next;
        end
    end

    assign req_ready = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign spi_clk   = sclk_reg;
    assign spi_mosi  = mosi_reg;
    assign spi_nss   = nss_reg;

endmodule

// File: tb/tb_synth_spi_tx.sv
// Bench for synth_spi_tx: a frame-timing model plus a small SPI receiver, checked every cycle,
// on two instances (CLK_DIV=4 and CLK_DIV=1).
module tb_synth_spi_tx;

`ifdef SPI_TX_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        vld [2];
    logic        rdy [2];
    logic [3:0]  a   [2];
    logic [11:0] dd  [2];
    logic        bsy [2];
    logic        dn  [2];
    logic        sck [2];
    logic        mo  [2];
    logic        ns  [2];

    int checks;
    int errors;
    int cyc;

    // model state
    logic        act  [2];
    int          k    [2];
    logic [15:0] frm  [2];
    logic        pend [2];
    int          acc_cnt [2];
    int          acc_cyc [2];

    // receiver / measurement state
    logic        psck [2];
    logic        pns  [2];
    logic        prdy [2];
    int          rx_cnt [2];
    logic [15:0] rx_sh  [2];
    int          low_run [2];
    int          win_edges [2];
    int          last_low [2];
    int          last_edges [2];
    int          last_rise [2];
    int          done_cnt [2];
    int          frames [2];
    int          rdy_rise [2];
    logic [15:0] last_frame [2];
    logic [15:0] prev_frame [2];
    logic [11:0] regs [2][16];

    synth_spi_tx #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_addr(a[0]), .req_data(dd[0]), .busy(bsy[0]), .done(dn[0]),
        .spi_clk(sck[0]), .spi_mosi(mo[0]), .spi_nss(ns[0])
    );

    synth_spi_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_addr(a[1]), .req_data(dd[1]), .busy(bsy[1]), .done(dn[1]),
        .spi_clk(sck[1]), .spi_mosi(mo[1]), .spi_nss(ns[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Expected {ready, busy, done, spi_clk, mosi, nss} at offset kk (1-based cycle after acceptance).
    // A frame is 34 segments of d cycles: SETUP, 16 HI / 15 LO interleaved, HOLD, GAP.
    function automatic logic [5:0] exp_outs(input logic a_, input int kk, input logic [15:0] f,
                                            input int d, input logic pd);
        int   s;
        logic r, dn_, sc, mo_, ns_;
        if (!a_) return 6'b100001;
        s   = (kk - 1) / d;
        dn_ = pd || ((kk - 1) == 33 * d);
        r   = BURST && (kk == 33 * d);
        ns_ = (s >= 33);
        sc  = (s >= 1) && (s <= 31) && (s % 2 == 1);
        if (s == 0)
            mo_ = f[15];
        else if (s <= 31)
            mo_ = (s % 2 == 1) ? f[15 - (s - 1) / 2] : f[15 - s / 2];
        else if (s == 32)
            mo_ = f[0];
        else
            mo_ = 1'b0;
        return {r, 1'b1, dn_, sc, mo_, ns_};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic run_compare();
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                int  d;
                bit  ok;
                d = div_of(i);
                if (rst) begin
                    act[i]  = 1'b0;
                    pend[i] = 1'b0;
                end else begin
                    ok = !act[i] || (BURST && k[i] == 33 * d);
                    if (vld[i] && ok) begin
                        pend[i] = act[i];
                        frm[i]  = {a[i], dd[i]};
                        act[i]  = 1'b1;
                        k[i]    = 1;
                        acc_cnt[i]++;
                        acc_cyc[i] = cyc;
                    end else if (act[i]) begin
                        pend[i] = 1'b0;
                        if (k[i] == 34 * d) act[i] = 1'b0;
                        else k[i]++;
                    end
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                logic [5:0] got;
                got = {rdy[i], bsy[i], dn[i], sck[i], mo[i], ns[i]};
                chk($sformatf("outs%0d", i), {26'd0, got},
                    {26'd0, exp_outs(act[i], k[i], frm[i], div_of(i), pend[i])});
                if (dn[i]) done_cnt[i]++;
                if (rdy[i] && !prdy[i]) rdy_rise[i] = cyc;
                if (sck[i] && !psck[i] && !ns[i]) begin
                    if (rx_cnt[i] > 0)
                        chk($sformatf("sck_period%0d", i), cyc - last_rise[i], 2 * div_of(i));
                    last_rise[i] = cyc;
                    rx_sh[i] = {rx_sh[i][14:0], mo[i]};
                    rx_cnt[i]++;
                    win_edges[i]++;
                    if (rx_cnt[i] == 16) begin
                        prev_frame[i] = last_frame[i];
                        last_frame[i] = rx_sh[i];
                        regs[i][rx_sh[i][15:12]] = rx_sh[i][11:0];
                        frames[i]++;
                        rx_cnt[i] = 0;
                    end
                end
                if (!ns[i]) low_run[i]++;
                if (ns[i] && !pns[i]) begin
                    last_low[i]   = low_run[i];
                    last_edges[i] = win_edges[i];
                    low_run[i]    = 0;
                    win_edges[i]  = 0;
                    rx_cnt[i]     = 0;
                end
                psck[i] = sck[i];
                pns[i]  = ns[i];
                prdy[i] = rdy[i];
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the model saw the transfer.
    task automatic send(input int i, input logic [3:0] ad, input logic [11:0] da, input bit keep);
        int c0, n;
        c0 = acc_cnt[i];
        n  = 0;
        a[i] = ad; dd[i] = da; vld[i] = 1'b1;
        while (acc_cnt[i] == c0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept%0d", i), {31'd0, acc_cnt[i] != c0}, 32'd1);
        if (!keep) vld[i] = 1'b0;
        $display("inst %0d: request addr=%0h data=%03h accepted at cycle %0d", i, ad, da, acc_cyc[i]);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((act[i] || vld[i]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout%0d", i), {31'd0, act[i]}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic stimulus();
        int a1, d0, f0;
        logic [11:0] wr [8];
        wr[0] = 12'h0A1; wr[1] = 12'h0B2; wr[2] = 12'h0C3; wr[3] = 12'h0D4;
        wr[4] = 12'h5A5; wr[5] = 12'h0E6; wr[6] = 12'h0F7; wr[7] = 12'h002;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", {26'd0, rdy[0], bsy[0], dn[0], sck[0], mo[0], ns[0]}, 32'h21);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single frame, CLK_DIV=4
        d0 = done_cnt[0];
        send(0, 4'h4, 12'h3A5, 1'b0);
        wait_idle(0);
        chk("frame_43A5", {16'd0, last_frame[0]}, 32'h43A5);
        chk("edges_16", last_edges[0], 16);
        chk("nss_low_132", last_low[0], 132);
        chk("done_once", done_cnt[0] - d0, 1);
        chk("ready_137", rdy_rise[0] - acc_cyc[0] + 1, 137);

        // back-to-back writes to 0..7 with valid held
        f0 = frames[0];
        for (int j = 0; j < 8; j++) send(0, 4'(j), wr[j], j != 7);
        wait_idle(0);
        chk("frames_8", frames[0] - f0, 8);
        for (int j = 0; j < 7; j++)
            chk($sformatf("reg%0d", j), {20'd0, regs[0][j] & ((j == 4) ? 12'hFFF : 12'h0FF)},
                {20'd0, wr[j] & ((j == 4) ? 12'hFFF : 12'h0FF)});
        chk("mute", {31'd0, regs[0][7][0]}, 32'd0);
        chk("trig", {31'd0, regs[0][7][1]}, 32'd1);

        // inputs change while busy
        send(0, 4'h5, 12'h011, 1'b0);
        a1 = acc_cyc[0];
        repeat (10) @(negedge clk);
        a[0] = 4'h9; dd[0] = 12'hABC;
        repeat (5) @(negedge clk);
        send(0, 4'h6, 12'h022, 1'b0);
        wait_idle(0);
        chk("frame_unchanged", {16'd0, prev_frame[0]}, 32'h5011);
        chk("frame_second", {16'd0, last_frame[0]}, 32'h6022);
        chk("second_accept", acc_cyc[0] - a1, BURST ? 33 * 4 : 34 * 4 + 1);

        // reset at bit 7 of a frame
        d0 = done_cnt[0];
        send(0, 4'h3, 12'h0FF, 1'b0);
        begin
            int n;
            n = 0;
            while (rx_cnt[0] != 7 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("reach_bit7", rx_cnt[0], 7);
        end
        rst = 1'b1;
        #1;
        chk("rst_async", {29'd0, ns[0], sck[0], mo[0]}, 32'h4);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_done_abort", done_cnt[0] - d0, 0);
        chk("reg3_kept", {20'd0, regs[0][3] & 12'h0FF}, 32'hD4);
        send(0, 4'h2, 12'h080, 1'b0);
        wait_idle(0);
        chk("frame_2080", {16'd0, last_frame[0]}, 32'h2080);
        chk("reg2", {20'd0, regs[0][2] & 12'h0FF}, 32'h80);

        // CLK_DIV=1
        send(1, 4'hF, 12'hFFF, 1'b0);
        wait_idle(1);
        chk("frame_FFFF", {16'd0, last_frame[1]}, 32'hFFFF);
        chk("edges_16_d1", last_edges[1], 16);
        chk("nss_low_33", last_low[1], 33);
        chk("ready_35", rdy_rise[1] - acc_cyc[1] + 1, 35);

`ifdef SPI_TX_BURST_EN
        d0 = done_cnt[0];
        send(0, 4'h1, 12'h011, 1'b1);
        send(0, 4'h6, 12'h066, 1'b0);
        wait_idle(0);
        chk("burst_edges_32", last_edges[0], 32);
        chk("burst_done_2", done_cnt[0] - d0, 2);
        chk("burst_f1", {16'd0, prev_frame[0]}, 32'h1011);
        chk("burst_f2", {16'd0, last_frame[0]}, 32'h6066);
`endif
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; a[i] = 4'h0; dd[i] = 12'h000;
            act[i] = 1'b0; k[i] = 0; frm[i] = 16'h0; pend[i] = 1'b0;
            acc_cnt[i] = 0; acc_cyc[i] = 0;
            psck[i] = 1'b0; pns[i] = 1'b1; prdy[i] = 1'b1;
            rx_cnt[i] = 0; rx_sh[i] = 16'h0; low_run[i] = 0; win_edges[i] = 0;
            last_low[i] = 0; last_edges[i] = 0; last_rise[i] = 0; done_cnt[i] = 0;
            frames[i] = 0; rdy_rise[i] = 0; last_frame[i] = 16'h0; prev_frame[i] = 16'h0;
            for (int j = 0; j < 16; j++) regs[i][j] = 12'h000;
        end
        fork
            run_compare();
            stimulus();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
